rng_arbiter: RTL
================

RNG_ARBITER -- requirements
Module: rng_arbiter

Interface
REQ-001 Parameter SEED, default 5'h0F, LFSR reset/recovery value; SHALL be non-zero.
REQ-002 Parameter SHIFTS, default 5, LFSR shifts per draw; SHALL be 1..7.
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port req  input  4  per-requester draw request, level; bit i = requester i.
REQ-006 Port mod_in  input  20  per-requester modulus; requester i uses bits [5i+4:5i]; 0 = no reduction.
REQ-007 Port gnt  output  4  one-hot, 1-cycle pulse marking the requester whose result is on rnd.
REQ-008 Port valid  output  1  high exactly when gnt is non-zero.
REQ-009 Port rnd  output  5  reduced random value; meaningful only while valid.
REQ-010 Port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-011 Internal 5-bit LFSR SHALL shift as lfsr <= {lfsr[3:0], lfsr[4]^lfsr[2]} only while in SHIFT; it SHALL hold in all other states.
REQ-012 If lfsr is ever 0, it SHALL load SEED on the next edge instead of shifting.
REQ-013 FSM states SHALL be IDLE, SHIFT, REDUCE, DONE.
REQ-014 IDLE: if req != 0, SHALL select winner by round-robin, searching from (last+1) mod 4 upward; latch winner index and its 5-bit modulus; clear shift counter; go SHIFT. If req == 0, stay IDLE.
REQ-015 SHIFT: one shift per cycle; on the SHIFTS-th shift, load acc with the shifted value and go REDUCE (exactly SHIFTS cycles in SHIFT).
REQ-016 REDUCE: latched modulus 0 -> go DONE next edge, acc unchanged; else if acc >= modulus, acc <= acc - modulus and stay; else go DONE. One subtraction per cycle; worst case 32 REDUCE cycles (modulus 1).
REQ-017 DONE: drive gnt[winner]=1, valid=1, rnd=acc for exactly one cycle; update last=winner; return to IDLE.
REQ-018 Latency from the edge sampling req in IDLE to the gnt cycle SHALL be SHIFTS+1+k edges, k = subtractions performed (default: 6+k).
REQ-019 req/mod_in changes after the IDLE arbitration edge SHALL NOT affect the draw in progress; the draw completes and gnt pulses even if the winner dropped req.
REQ-020 A requester holding req high after its gnt SHALL be re-arbitrated on the IDLE cycle following DONE; minimum spacing between grants is therefore SHIFTS+3 cycles.
REQ-021 Requests arriving while busy SHALL wait; none are lost while held high; none are queued if released before arbitration.
REQ-022 Round-robin SHALL guarantee that with all four req high, grants occur in order 0,1,2,3,0,...

Reset
REQ-023 On reset assertion, asynchronously: lfsr=SEED, state=IDLE, shift counter=0, acc=0, last=3, gnt=0, valid=0, rnd=0, busy=0.
REQ-024 Reset asserted mid-draw SHALL abort it with no gnt pulse; first request after release is arbitrated from requester 0.
REQ-025 Outputs SHALL remain at reset values until the first draw completes.

Verification
REQ-026 Reset, req=4'b0001, mod0=28 -> after 5 shifts lfsr=17; gnt=4'b0001, valid=1, rnd=17 in cycle after edge E0+6; busy low after.
REQ-027 Reset, req=4'b0010, mod1=5 -> lfsr=17, 3 subtractions, rnd=2, gnt=4'b0010 at E0+9.
REQ-028 Reset, req0 held high, mod0=0 -> first rnd=17, second rnd=23 (lfsr 10001 -> 00011 -> 00110 -> 01101 -> 11011 -> 10111), grants 8 cycles apart.
REQ-029 Reset, req=4'b1111 held, all mods 0 -> gnt sequence 0001,0010,0100,1000,0001; valid matches each gnt; never two bits set.
REQ-030 Reset asserted 3 cycles into SHIFT -> no gnt; busy=0, lfsr=5'h0F immediately; subsequent draw with mod=0 yields rnd=17.
REQ-031 req0 pulsed one cycle in IDLE, mod0=1 -> draw completes with rnd=0 at E0+6+17; req change during draw ignored.

Source files
------------

// File: rtl/rng_arbiter.sv
// rng_arbiter: four-requester round-robin arbiter that serves each winner a
// 5-bit LFSR draw, reduced modulo a per-requester modulus by repeated subtraction.
module rng_arbiter #(
    parameter logic [4:0]  SEED   = 5'h0F,
    parameter int unsigned SHIFTS = 5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [19:0] mod_in,
    output logic [3:0]  gnt,
    output logic        valid,
    output logic [4:0]  rnd,
    output logic        busy
);

    localparam int unsigned N_REQ = 4;
    localparam int unsigned W     = 5;
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REDUCE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state, state_n;
    logic [W-1:0]       lfsr, lfsr_n;
    logic [W-1:0]       acc, acc_n;
    logic [W-1:0]       modulus, modulus_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [1:0]         last, last_n;
    logic [1:0]         winner, winner_n;
    logic [3:0]         gnt_n;
    logic               valid_n;
    logic [W-1:0]       rnd_n;
    logic               busy_n;

    logic [1:0]         pick;
    logic               found;
    logic [1:0]         idx;
    logic [W-1:0]       lfsr_shifted;
    logic [W-1:0]       pick_mod;

    // Round-robin search starting just after the previous winner
    always_comb begin
        pick  = 2'd0;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Modulus slice of the candidate winner and the next LFSR value
    always_comb begin
        pick_mod     = mod_in[W*int'(pick) +: W];
        lfsr_shifted = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n   = state;
        lfsr_n    = lfsr;
        acc_n     = acc;
        modulus_n = modulus;
        cnt_n     = cnt;
        last_n    = last;
        winner_n  = winner;
        gnt_n     = 4'b0000;
        valid_n   = 1'b0;
        rnd_n     = rnd;

        case (state)
            IDLE: begin
                if (found) begin
                    winner_n  = pick;
                    modulus_n = pick_mod;
                    cnt_n     = '0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                lfsr_n = lfsr_shifted;
                cnt_n  = cnt + CNT_W'(1);
                if (cnt == CNT_W'(SHIFTS - 1)) begin
                    acc_n   = lfsr_shifted;
                    state_n = REDUCE;
                end
            end
            REDUCE: begin
                if (modulus != '0 && acc >= modulus) begin
                    acc_n = acc - modulus;
                end else begin
                    state_n = DONE;
                    gnt_n   = 4'b0001 << winner;
                    valid_n = 1'b1;
                    rnd_n   = acc;
                end
            end
            DONE: begin
                last_n  = winner;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // An all-zero LFSR would lock up; recover to the seed instead
        if (lfsr == '0) begin
            lfsr_n = SEED;
        end

        busy_n = (state_n != IDLE);
    end

    // State and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lfsr    <= SEED;
            acc     <= '0;
            modulus <= '0;
            cnt     <= '0;
            last    <= 2'd3;
            winner  <= 2'd0;
            gnt     <= 4'b0000;
            valid   <= 1'b0;
            rnd     <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            lfsr    <= lfsr_n;
            acc     <= acc_n;
            modulus <= modulus_n;
            cnt     <= cnt_n;
            last    <= last_n;
            winner  <= winner_n;
            gnt     <= gnt_n;
            valid   <= valid_n;
            rnd     <= rnd_n;
            busy    <= busy_n;
        end
    end

endmodule
